fir_out_decimator: RTL and testbench

Output conditioning stage placed directly downstream of the 16-tap FIR filter. It consumes the filter's full-precision 2*WIDTH-bit output every clock and discards samples until the tap delay line has filled after reset. It then keeps one of every DECIM samples, rounds and saturates each kept sample to WIDTH bits, and buffers the results in a small FIFO. A valid/ready handshake presents them to the next consumer.

---
 rtl/fir_out_decimator_if.sv | 32 +++
 rtl/fir_out_decimator.sv | 150 +++++++++++++++
 tb/tb_fir_out_decimator.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_out_decimator_if.sv
// Stream-side bundle of the FIR output decimator: the full-precision filter
// sample going in, and the rounded, decimated sample plus status going out.
interface fir_out_decimator_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] i_signal;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_signal;
  logic               o_sat;
  logic               o_drop;

  // Decimator side: produces the output stream and the sticky flags.
  modport master (
    input  i_signal,
    input  i_ready,
    output o_valid,
    output o_signal,
    output o_sat,
    output o_drop
  );

  // Surrounding logic side: feeds filter samples and consumes the stream.
  modport slave (
    output i_signal,
    output i_ready,
    input  o_valid,
    input  o_signal,
    input  o_sat,
    input  o_drop
  );
endinterface

// File: rtl/fir_out_decimator.sv
// FIR output conditioning: skip the filter warm-up, keep one sample in DECIM,
// round-half-up and saturate to WIDTH bits, and queue the results in a small
// FIFO drained through a valid/ready handshake.
module fir_out_decimator #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 16,
  parameter int DECIM = 4,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  fir_out_decimator_if.master bus
);

  localparam int IW  = 2 * WIDTH;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = $clog2(TAPS + 2);
  localparam int PCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [IW:0]    HALF     = (IW + 1)'(1) << (SHIFT - 1);
  localparam logic [WCW-1:0] WARM_END = WCW'(TAPS);
  localparam logic [PCW-1:0] PH_LAST  = PCW'(DECIM - 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  // Front end: warm-up and decimation phase.
  logic [WCW-1:0] warm_cnt;
  logic [PCW-1:0] phase;
  logic           warm_done;
  logic           keep;

  // Rounding / saturation of the incoming sample.
  logic [IW:0]      sum;
  logic [IW:0]      scaled;
  logic             over;
  logic [WIDTH-1:0] result;

  // Conditioning register.
  logic             pend_v;
  logic [WIDTH-1:0] pend_d;
  logic             sat_q;
  logic             drop_q;

  // Output FIFO.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             valid_q;
  logic [WIDTH-1:0] signal_q;

  logic             pop;
  logic             push;
  logic             drop_now;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] head_next;

  assign warm_done = (warm_cnt == WARM_END);
  assign keep      = warm_done && (phase == '0);

  // Round half up in IW+1 bits so the bias add never wraps, then clamp.
  always_comb begin
    sum    = {1'b0, bus.i_signal} + HALF;
    scaled = sum >> SHIFT;
    over   = |scaled[IW:WIDTH];
    result = over ? '1 : scaled[WIDTH-1:0];
  end

  // Warm-up counter saturates at TAPS; the phase only runs once it has.
  // NOTE: state registers use <= so every block samples pre-edge values regardless of ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
      phase    <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end else begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  // Conditioning register: one stage between arithmetic and FIFO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend_d <= '0;
      sat_q  <= 1'b0;
    end else begin
      pend_v <= keep;
      if (keep) begin
        pend_d <= result;
        if (over) sat_q <= 1'b1;
      end
    end
  end

  // FIFO next-state: a full FIFO still accepts a write when it pops that cycle.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pop         = valid_q & bus.i_ready;
    push        = 1'b0;
    drop_now    = 1'b0;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    head_next   = '0;
    if (pend_v) begin
      if ((count != FULL_CNT) || pop) push = 1'b1;
      else                            drop_now = 1'b1;
    end
    if (pop) rd_ptr_next = rd_ptr + 1'b1;
    count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
    // The new head is the entry being written when it lands in the read slot.
    if (count_next != '0) begin
      if (push && (wr_ptr == rd_ptr_next)) head_next = pend_d;
      else                                 head_next = mem[rd_ptr_next];
    end
  end

  // FIFO bookkeeping and registered head presentation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      signal_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      valid_q  <= (count_next != '0);
      signal_q <= head_next;
      if (drop_now) drop_q <= 1'b1;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pend_d;
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_signal = signal_q;
  assign bus.o_sat    = sat_q;
  assign bus.o_drop   = drop_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: a DECIM=4 and a DECIM=1 instance share clock
// and reset, each tracked by a transaction-level model built from queues of
// samples and plain arithmetic.
module tb_fir_out_decimator;

  localparam int WIDTH = 16;
  localparam int TAPS  = 16;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] x;
    logic [15:0] y;
    bit          sat;
  } vec_t;

  logic clk;
  logic rst;

  fir_out_decimator_if #(.WIDTH(WIDTH)) bus4 ();
  fir_out_decimator_if #(.WIDTH(WIDTH)) bus1 ();

  fir_out_decimator #(.WIDTH(WIDTH), .TAPS(TAPS), .DECIM(4), .SHIFT(SHIFT), .DEPTH(DEPTH))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  fir_out_decimator #(.WIDTH(WIDTH), .TAPS(TAPS), .DECIM(1), .SHIFT(SHIFT), .DEPTH(DEPTH))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = DECIM 4, index 1 = DECIM 1.
  int          m_edges [2];
  bit          m_pv    [2];
  logic [15:0] m_pd    [2];
  logic [15:0] m_q     [2][DEPTH];
  int          m_cnt   [2];
  bit          m_sat   [2];
  bit          m_drop  [2];

  logic [15:0] popped [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decim_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_edges[d] = 0;
      m_pv[d]    = 1'b0;
      m_pd[d]    = '0;
      m_cnt[d]   = 0;
      m_sat[d]   = 1'b0;
      m_drop[d]  = 1'b0;
    end
  endtask

  // One rising edge of the model: pop, then commit pending, then sample input.
  task automatic model_edge(input int d, input logic [31:0] x, input bit rdy);
    longint s;
    bit kept;
    if (m_cnt[d] != 0 && rdy) begin
      for (int i = 0; i < DEPTH - 1; i++) m_q[d][i] = m_q[d][i+1];
      m_cnt[d]--;
    end
    if (m_pv[d]) begin
      if (m_cnt[d] < DEPTH) begin
        m_q[d][m_cnt[d]] = m_pd[d];
        m_cnt[d]++;
      end else begin
        m_drop[d] = 1'b1;
      end
    end
    kept = (m_edges[d] >= TAPS) && (((m_edges[d] - TAPS) % decim_of(d)) == 0);
    m_edges[d]++;
    m_pv[d] = kept;
    if (kept) begin
      s = (longint'(x) + (longint'(1) << (SHIFT - 1))) >> SHIFT;
      if (s > 65535) begin
        m_pd[d]  = 16'hFFFF;
        m_sat[d] = 1'b1;
      end else begin
        m_pd[d] = 16'(s);
      end
    end
  endtask

  task automatic compare_all();
    check("valid4", 32'(bus4.o_valid),  32'(m_cnt[0] != 0));
    check("sig4",   32'(bus4.o_signal), (m_cnt[0] != 0) ? 32'(m_q[0][0]) : 32'd0);
    check("sat4",   32'(bus4.o_sat),    32'(m_sat[0]));
    check("drop4",  32'(bus4.o_drop),   32'(m_drop[0]));
    check("valid1", 32'(bus1.o_valid),  32'(m_cnt[1] != 0));
    check("sig1",   32'(bus1.o_signal), (m_cnt[1] != 0) ? 32'(m_q[1][0]) : 32'd0);
    check("sat1",   32'(bus1.o_sat),    32'(m_sat[1]));
    check("drop1",  32'(bus1.o_drop),   32'(m_drop[1]));
  endtask

  // Called at a falling edge: drive, clock, update model, compare at next fall.
  task automatic cycle(input logic [31:0] x4, input logic [31:0] x1, input bit r4, input bit r1);
    bus4.i_signal = x4;
    bus4.i_ready  = r4;
    bus1.i_signal = x1;
    bus1.i_ready  = r1;
    @(posedge clk);
    model_edge(0, x4, r4);
    model_edge(1, x1, r1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{x: 32'h0000_007F, y: 16'h0000, sat: 1'b0};
    vecs[1] = '{x: 32'h0000_0080, y: 16'h0001, sat: 1'b0};
    vecs[2] = '{x: 32'h0000_1280, y: 16'h0013, sat: 1'b0};
    vecs[3] = '{x: 32'h00FF_FF7F, y: 16'hFFFF, sat: 1'b0};
    vecs[4] = '{x: 32'h00FF_FFFF, y: 16'hFFFF, sat: 1'b1};
    vecs[5] = '{x: 32'h0000_0100, y: 16'h0001, sat: 1'b1};
    vecs[6] = '{x: 32'hFFFF_FFFF, y: 16'hFFFF, sat: 1'b1};
    vecs[7] = '{x: 32'h0012_3456, y: 16'h1234, sat: 1'b1};

    rst = 1'b1;
    bus4.i_signal = '0;
    bus4.i_ready  = 1'b0;
    bus1.i_signal = '0;
    bus1.i_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",  32'(bus4.o_valid),  32'd0);
    check("rst_signal", 32'(bus4.o_signal), 32'd0);
    check("rst_sat",    32'(bus4.o_sat),    32'd0);
    check("rst_drop",   32'(bus4.o_drop),   32'd0);
    rst = 1'b0;

    // Incrementing ramp with the consumer always ready: 1-clock valid pulses.
    for (int e = 1; e <= 34; e++) begin
      cycle(32'(e - 1), 32'(e - 1), 1'b1, 1'b1);
      check("pulse4", 32'(bus4.o_valid), 32'(e >= TAPS + 2 && ((e - TAPS - 2) % 4) == 0));
    end

    // Rounding and saturation vectors on the keep-every-sample instance.
    foreach (vecs[i]) begin
      repeat (3) cycle(vecs[i].x, vecs[i].x, 1'b1, 1'b1);
      check("tbl_sig", 32'(bus1.o_signal), 32'(vecs[i].y));
      check("tbl_sat", 32'(bus1.o_sat),    32'(vecs[i].sat));
    end

    // Backpressure: DECIM=1 fills and drops; DECIM=4 fills then pops and pushes together.
    do_reset();
    popped.delete();
    for (int e = 1; e <= 40; e++) begin
      bit r4, r1;
      r4 = (e >= 34);
      r1 = (e >= 25);
      if (bus1.o_valid && r1) popped.push_back(bus1.o_signal);
      cycle(32'(e) << 8, 32'(e) << 8, r4, r1);
      if (e == 21) check("no_drop_yet1", 32'(bus1.o_drop), 32'd0);
      if (e == 22) check("drop5th1",     32'(bus1.o_drop), 32'd1);
      if (e == 30) check("full4_valid",  32'(bus4.o_valid), 32'd1);
      if (e == 34) begin
        check("pushpop_drop4", 32'(bus4.o_drop),   32'd0);
        check("pushpop_head4", 32'(bus4.o_signal), 32'd21);
      end
    end
    check("popped_cnt", (popped.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < popped.size()) check("drain_order", 32'(popped[i]), 32'(17 + i));
    end

    // Reset with three entries buffered, then a full warm-up again.
    do_reset();
    for (int e = 1; e <= 26; e++) cycle(32'(e) << 8, 32'(e) << 8, 1'b0, 1'b1);
    check("three_valid4", 32'(bus4.o_valid),  32'd1);
    check("three_head4",  32'(bus4.o_signal), 32'd17);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_valid4", 32'(bus4.o_valid),  32'd0);
    check("async_sig4",   32'(bus4.o_signal), 32'd0);
    check("async_drop1",  32'(bus1.o_drop),   32'd0);
    check("async_sat4",   32'(bus4.o_sat),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      cycle(32'(e + 100) << 8, 32'(e) << 8, 1'b1, 1'b1);
      check("rewarm_valid4", 32'(bus4.o_valid), 32'(e == TAPS + 2 || e == TAPS + 6));
      if (e == TAPS + 2) check("rewarm_sig4", 32'(bus4.o_signal), 32'(TAPS + 1 + 100));
    end

    // Randomized traffic against the model, with in-range and overflowing samples.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h00FF_FFFF));
      b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h00FF_FFFF));
      cycle(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
